// File: rtl/control_unit_pipe.sv
// control_unit_pipe: pipelined RV32I(+M) main decoder with D/E control register.
// Decodes instr_d combinationally and registers all control fields into E.
// Multi-cycle mul/div occupancy is tracked by a down-counter that back-pressures D.
// Optional: define CONTROL_UNIT_PIPE_ILLEGAL_EN to add illegal_e and keep
// illegal instructions live in E; otherwise they are captured as bubbles.
module control_unit_pipe #(
    parameter int M_EXT      = 1,
    parameter int ALU_CTRL_W = 5,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic                  valid_d,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic                  valid_e,
    output logic                  reg_write_e,
    output logic [1:0]            res_src_e,
    output logic                  mem_write_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic [2:0]            imm_src_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic [2:0]            funct3_e,
    output logic                  md_busy,
    output logic                  stall_d
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
    ,
    output logic                  illegal_e
`endif
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_SLT  = 5'b00011;
    localparam logic [4:0] ALU_SLTU = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b00101;
    localparam logic [4:0] ALU_SRL  = 5'b00110;
    localparam logic [4:0] ALU_SRA  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b01001;
    localparam logic [4:0] ALU_PASS = 5'b01101;

    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Field order: reg_write, res_src[1:0], mem_write, jump, branch, alu_src_a, alu_src_b, imm_src[2:0]
    logic [10:0]      ctrl_d, ctrl_q;
    logic [4:0]       alu5_d;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             illegal, m_op, div_op, live, need_busy;
    logic [CNT_W-1:0] cnt_q, cnt_load;
    logic [4:0]       alu_q;
    logic [2:0]       f3_q;
    logic             valid_q, illegal_q;
    logic             unused_bits;

    assign funct3      = instr_d[14:12];
    assign funct7      = instr_d[31:25];
    assign unused_bits = ^{instr_d[24:15], instr_d[11:7], illegal_q};

    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            3'b000:  base_alu = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    // Main decode: control fields, ALU operation, legality and mul/div class.
    always_comb begin
        ctrl_d  = '0;
        alu5_d  = ALU_ADD;
        illegal = 1'b0;
        m_op    = 1'b0;
        div_op  = 1'b0;
        case (instr_d[6:0])
            OPC_LOAD:   ctrl_d = 11'b1_01_0_0_0_0_1_000;
            OPC_OP_IMM: begin
                ctrl_d = 11'b1_00_0_0_0_0_1_000;
                alu5_d = base_alu(funct3, funct7[5], 1'b0);
            end
            OPC_AUIPC:  ctrl_d = 11'b1_00_0_0_0_1_1_100;
            OPC_STORE:  ctrl_d = 11'b0_01_1_0_0_0_1_001;
            OPC_OP: begin
                if (funct7 == 7'b0000001) begin
                    if (M_EXT != 0) begin
                        ctrl_d = 11'b1_00_0_0_0_0_0_000;
                        alu5_d = {2'b10, funct3};
                        m_op   = 1'b1;
                        div_op = funct3[2];
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    ctrl_d = 11'b1_00_0_0_0_0_0_000;
                    alu5_d = base_alu(funct3, funct7[5], 1'b1);
                end
            end
            OPC_LUI: begin
                ctrl_d = 11'b1_00_0_0_0_0_1_100;
                alu5_d = ALU_PASS;
            end
            OPC_BRANCH: ctrl_d = 11'b0_00_0_0_1_1_1_010;
            OPC_JALR:   ctrl_d = 11'b1_10_0_1_0_0_1_000;
            OPC_JAL:    ctrl_d = 11'b1_10_0_1_0_1_1_011;
            default:    illegal = 1'b1;
        endcase
    end

    // Occupancy request for a live M op whose latency exceeds one cycle.
    always_comb begin
        live      = valid_d & ~illegal;
        need_busy = live & m_op & (div_op ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1));
        cnt_load  = div_op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
    end

    // E register and occupancy counter: flush beats hold beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            alu_q     <= '0;
            f3_q      <= '0;
            cnt_q     <= '0;
        end else if (flush_e) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
            alu_q     <= '0;
            f3_q      <= '0;
            cnt_q     <= '0;
        end else if (md_busy || stall_e) begin
            if (md_busy)
                cnt_q <= cnt_q - CNT_W'(1);
        end else begin
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
            valid_q   <= valid_d;
            illegal_q <= valid_d & illegal;
`else
            valid_q   <= live;
            illegal_q <= 1'b0;
`endif
            ctrl_q    <= live ? ctrl_d : '0;
            alu_q     <= live ? alu5_d : '0;
            f3_q      <= live ? funct3 : '0;
            cnt_q     <= need_busy ? cnt_load : '0;
        end
    end

    assign valid_e       = valid_q;
    assign {reg_write_e, res_src_e, mem_write_e, jump_e, branch_e,
            alu_src_a_e, alu_src_b_e, imm_src_e} = ctrl_q;
    assign alu_control_e = ALU_CTRL_W'(alu_q);
    assign funct3_e      = f3_q;
    assign md_busy       = (cnt_q != '0);
    assign stall_d       = md_busy | stall_e;
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
    assign illegal_e     = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe (default parameters).
module tb_control_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        valid_d, stall_e, flush_e;
    logic        valid_e, reg_write_e, mem_write_e, jump_e, branch_e;
    logic        alu_src_a_e, alu_src_b_e, md_busy, stall_d;
    logic [1:0]  res_src_e;
    logic [2:0]  imm_src_e, funct3_e;
    logic [4:0]  alu_control_e;
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
    logic        illegal_e;
`endif

    int total = 0;
    int bad   = 0;
    logic [20:0] exp_q[$];
    logic [20:0] e;
    logic [20:0] obs;

    always #5 clk = ~clk;

    control_unit_pipe #(.M_EXT(1), .ALU_CTRL_W(5), .MUL_CYCLES(1), .DIV_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
        .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e),
        .reg_write_e(reg_write_e), .res_src_e(res_src_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e), .alu_src_a_e(alu_src_a_e),
        .alu_src_b_e(alu_src_b_e), .imm_src_e(imm_src_e), .alu_control_e(alu_control_e),
        .funct3_e(funct3_e), .md_busy(md_busy), .stall_d(stall_d)
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
        , .illegal_e(illegal_e)
`endif
    );

    assign obs = {valid_e, reg_write_e, res_src_e, mem_write_e, jump_e, branch_e,
                  alu_src_a_e, alu_src_b_e, imm_src_e, alu_control_e, funct3_e, md_busy};

    localparam logic [10:0] C_LOAD  = 11'b1_01_0_0_0_0_1_000;
    localparam logic [10:0] C_OPIMM = 11'b1_00_0_0_0_0_1_000;
    localparam logic [10:0] C_STORE = 11'b0_01_1_0_0_0_1_001;
    localparam logic [10:0] C_OP    = 11'b1_00_0_0_0_0_0_000;
    localparam logic [10:0] C_LUI   = 11'b1_00_0_0_0_0_1_100;
    localparam logic [10:0] C_BR    = 11'b0_00_0_0_1_1_1_010;
    localparam logic [10:0] C_JAL   = 11'b1_10_0_1_0_1_1_011;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SUB  = 32'h40208033;
    localparam logic [31:0] I_SRAI = 32'h4010D093;
    localparam logic [31:0] I_DIV  = 32'h0220C0B3;
    localparam logic [31:0] I_ADD  = 32'h002080B3;

    function automatic logic [20:0] mk(input logic v, input logic [10:0] c,
                                       input logic [4:0] alu, input logic [2:0] f3,
                                       input logic busy);
        mk = {v, c, alu, f3, busy};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_d = '0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
        #2;
        total++;
        if (obs !== 21'd0) begin bad++; $display("FAIL reset_state got=%h want=0", obs); end
        total++;
        if (stall_d !== 1'b0) begin bad++; $display("FAIL reset_stall_d got=%b want=0", stall_d); end
        tick; tick;
        rst_n = 1'b1;
        exp_q.push_back(21'd0);
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs, e); end
    endtask

    task automatic test_decode;
        logic [31:0] ins [7];
        logic [20:0] ex  [7];
        ins[0] = I_ADDI;       ex[0] = mk(1, C_OPIMM, 5'd0,  3'd0, 0);
        ins[1] = 32'h0020A023; ex[1] = mk(1, C_STORE, 5'd0,  3'd2, 0);
        ins[2] = 32'h000000EF; ex[2] = mk(1, C_JAL,   5'd0,  3'd0, 0);
        ins[3] = 32'h123450B7; ex[3] = mk(1, C_LUI,   5'd13, 3'd5, 0);
        ins[4] = 32'h00208063; ex[4] = mk(1, C_BR,    5'd0,  3'd0, 0);
        ins[5] = 32'h022080B3; ex[5] = mk(1, C_OP,    5'd16, 3'd0, 0);
        ins[6] = 32'h0000A103; ex[6] = mk(1, C_LOAD,  5'd0,  3'd2, 0);
        for (int i = 0; i < 7; i++) begin
            instr_d = ins[i]; valid_d = 1'b1;
            exp_q.push_back(ex[i]);
            tick;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL decode_%0d got=%h want=%h", i, obs, e); end
        end
        instr_d = I_ADD; valid_d = 1'b0;
        exp_q.push_back(21'd0);
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL invalid_capture got=%h want=%h", obs, e); end
    endtask

    task automatic test_back_to_back;
        instr_d = I_SUB; valid_d = 1'b1;
        exp_q.push_back(mk(1, C_OP, 5'd1, 3'd0, 0));
        tick;
        instr_d = I_SRAI;
        exp_q.push_back(mk(1, C_OPIMM, 5'd7, 3'd5, 0));
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_sub got=%h want=%h", obs, e); end
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_srai got=%h want=%h", obs, e); end
    endtask

    task automatic test_stall;
        instr_d = I_SUB; valid_d = 1'b1;
        exp_q.push_back(mk(1, C_OP, 5'd1, 3'd0, 0));
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL stall_pre got=%h want=%h", obs, e); end
        instr_d = I_ADD; stall_e = 1'b1;
        #1;
        total++;
        if (stall_d !== 1'b1) begin bad++; $display("FAIL stall_d_follow got=%b want=1", stall_d); end
        exp_q.push_back(mk(1, C_OP, 5'd1, 3'd0, 0));
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL stall_hold got=%h want=%h", obs, e); end
        stall_e = 1'b0;
        exp_q.push_back(mk(1, C_OP, 5'd0, 3'd0, 0));
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL stall_release got=%h want=%h", obs, e); end
    endtask

    task automatic test_div_busy;
        instr_d = I_DIV; valid_d = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(1, C_OP, 5'd20, 3'd4, 1));
        exp_q.push_back(mk(1, C_OP, 5'd20, 3'd4, 0));
        exp_q.push_back(mk(1, C_OP, 5'd0, 3'd0, 0));
        tick;
        instr_d = I_ADD;
        for (int i = 0; i < 7; i++) begin
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin bad++; $display("FAIL div_busy_%0d got=%h want=%h", i, obs, e); end
            total++;
            if (stall_d !== 1'b1) begin bad++; $display("FAIL div_stall_d_%0d got=%b want=1", i, stall_d); end
            tick;
        end
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL div_last got=%h want=%h", obs, e); end
        total++;
        if (stall_d !== 1'b0) begin bad++; $display("FAIL div_last_stall_d got=%b want=0", stall_d); end
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL div_next_add got=%h want=%h", obs, e); end
    endtask

    task automatic test_div_flush;
        instr_d = I_DIV; valid_d = 1'b1;
        tick;
        instr_d = I_ADD;
        tick; tick;
        exp_q.push_back(mk(1, C_OP, 5'd20, 3'd4, 1));
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL flush_busy3 got=%h want=%h", obs, e); end
        flush_e = 1'b1;
        exp_q.push_back(21'd0);
        tick;
        flush_e = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL flush_bubble got=%h want=%h", obs, e); end
        exp_q.push_back(mk(1, C_OP, 5'd0, 3'd0, 0));
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL flush_next got=%h want=%h", obs, e); end
    endtask

    task automatic test_illegal;
        instr_d = 32'hFFFFFFFF; valid_d = 1'b1;
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
        exp_q.push_back(mk(1, 11'd0, 5'd0, 3'd0, 0));
`else
        exp_q.push_back(21'd0);
`endif
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL illegal_capture got=%h want=%h", obs, e); end
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
        total++;
        if (illegal_e !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b want=1", illegal_e); end
`endif
        instr_d = I_ADDI;
        exp_q.push_back(mk(1, C_OPIMM, 5'd0, 3'd0, 0));
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL illegal_after got=%h want=%h", obs, e); end
`ifdef CONTROL_UNIT_PIPE_ILLEGAL_EN
        total++;
        if (illegal_e !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b want=0", illegal_e); end
`endif
    endtask

    task automatic test_reset_mid_div;
        instr_d = I_DIV; valid_d = 1'b1;
        tick;
        instr_d = I_ADD;
        tick; tick; tick;
        exp_q.push_back(mk(1, C_OP, 5'd20, 3'd4, 1));
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_busy4 got=%h want=%h", obs, e); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 21'd0) begin bad++; $display("FAIL rst_async got=%h want=0", obs); end
        total++;
        if (stall_d !== 1'b0) begin bad++; $display("FAIL rst_async_stall_d got=%b want=0", stall_d); end
        @(negedge clk);
        rst_n = 1'b1;
        instr_d = I_ADDI;
        exp_q.push_back(mk(1, C_OPIMM, 5'd0, 3'd0, 0));
        tick;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_after got=%h want=%h", obs, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_decode;
        test_back_to_back;
        test_stall;
        test_div_busy;
        test_div_flush;
        test_illegal;
        test_reset_mid_div;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle RV32I decoder.
- Decodes a 32-bit instruction in the D stage and registers all control fields into the D/E pipeline register.
- Adds optional RV32M decode and multi-cycle mul/div occupancy tracking, with back-pressure to fetch/decode.
- Sits between the fetch/decode register and the execute stage; the hazard unit drives its stall and flush inputs.

Parameters:
- M_EXT, 1, 1 = decode RV32M (funct7 = 0000001 on op 0110011); 0 = those encodings are illegal.
- ALU_CTRL_W, 5, ALU control width; must be >= 5 when M_EXT = 1, and >= 4 otherwise.
- MUL_CYCLES, 1, E-stage occupancy in cycles of MUL/MULH/MULHSU/MULHU; >= 1.
- DIV_CYCLES, 8, E-stage occupancy in cycles of DIV/DIVU/REM/REMU; >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_d  in  32  D-stage instruction.
- valid_d  in  1  instr_d is a real instruction.
- stall_e  in  1  hold the E register (hazard unit).
- flush_e  in  1  load a bubble into the E register.
- valid_e  out  1  E register holds a live instruction.
- reg_write_e  out  1  register-file write enable.
- res_src_e  out  2  result mux select: 00 ALU, 01 memory, 10 PC+4.
- mem_write_e  out  1  store enable.
- jump_e  out  1  jal/jalr.
- branch_e  out  1  conditional branch.
- alu_src_a_e  out  1  ALU A = PC.
- alu_src_b_e  out  1  ALU B = immediate.
- imm_src_e  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U.
- alu_control_e  out  ALU_CTRL_W  ALU operation.
- funct3_e  out  3  funct3 passthrough for branch compare and load/store size.
- md_busy  out  1  multi-cycle op occupying E.
- stall_d  out  1  = md_busy | stall_e; freezes fetch/decode.

Behaviour:
- Reset (async, rst_n = 0): every output and internal register is 0, including valid_e, md_busy and the counter.
- Decode is combinational from instr_d; E outputs appear 1 cycle after capture.
- Decode table (main control), per opcode:
  - load: 1_01_0_0_0_0_1_000
  - op-imm: 1_00_0_0_0_0_1_000
  - auipc: 1_00_0_0_0_1_1_100
  - store: 0_01_1_0_0_0_1_001
  - op: 1_00_0_0_0_0_0_000
  - lui: 1_00_0_0_0_0_1_100
  - branch: 0_00_0_0_1_1_1_010
  - jalr: 1_10_0_1_0_0_1_000
  - jal: 1_10_0_1_0_1_1_011
- ALU codes (zero-extended to ALU_CTRL_W):
  - base ops: add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001, pass-B (lui) 1101.
  - M ops: mul 10000, mulh 10001, mulhsu 10010, mulhu 10011, div 10100, divu 10101, rem 10110, remu 10111.
  - sub only for op with funct7[5] = 1; sra for funct3 101 with funct7[5] = 1, both op and op-imm.
  - load/store/auipc/branch/jal/jalr use add.
- E register update priority, per cycle:
  1. flush_e: bubble loaded; counter cleared; md_busy falls next cycle.
  2. md_busy or stall_e: hold all E outputs unchanged.
  3. Otherwise: capture the decode of instr_d; valid_e = valid_d.
- Bubble contents: valid_e = 0 and all control outputs 0.
- Any capture with valid_d = 0 also forces all control outputs to 0.
- Multi-cycle occupancy:
  - On capture of a valid M op with N = MUL_CYCLES or DIV_CYCLES > 1, the counter loads N-1 and md_busy = 1 the following cycle.
  - Counter decrements each cycle; md_busy = (counter != 0).
  - The E register is therefore held for exactly N cycles total.
  - N = 1: no busy.
  - stall_e during busy: counter still decrements.
- Illegal instruction (unknown opcode, or M encoding with M_EXT = 0):
  - captured as valid_e = 1 with all side-effect bits (reg_write, mem_write, jump, branch) = 0.
  - without the optional feature, captured as a bubble instead (see Optional Feature).
- No X is ever driven on any output.

Optional Feature:
- Macro: CONTROL_UNIT_PIPE_ILLEGAL_EN.
- Defined:
  - adds output illegal_e (1 bit), registered with the other E fields: 1 when the captured valid instruction is illegal; cleared by bubble, flush and reset.
  - illegal instructions keep valid_e = 1 so the trap logic can see them.
- Undefined:
  - no illegal_e port.
  - illegal instructions are captured as bubbles (valid_e = 0).

Test Plan:
- Reset then addi 0x00500093, valid_d = 1 -> next cycle:
  - valid_e = 1, reg_write_e = 1, alu_src_b_e = 1, imm_src_e = 000, alu_control_e = 00000, md_busy = 0.
- sub 0x40208033 then srai 0x4010D093 on consecutive cycles -> alu_control_e = 00001, then 00111.
- div 0x0220C0B3 (DIV_CYCLES = 8) with a following add on instr_d:
  - md_busy = 1 and stall_d = 1 for 7 cycles; E held at 10100.
  - the add is captured on the 8th cycle after the div.
- div, then flush_e pulsed on the 3rd busy cycle -> next cycle valid_e = 0, md_busy = 0; the next instruction is captured normally.
- instr_d = 0xFFFFFFFF with valid_d = 1:
  - macro defined: valid_e = 1, illegal_e = 1, reg_write_e = mem_write_e = 0.
  - macro undefined: valid_e = 0.
  - With M_EXT = 0, 0x0220C0B3 behaves identically.
- rst_n asserted mid-div (4th busy cycle), asynchronously -> all outputs 0 immediately; after release, the first valid instruction decodes with md_busy = 0.
